// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - 6502/2A03 ALU initiator: one op in flight, registered result and N/V/Z/C flags
// Optional DECIMAL_MODE_EN adds the ADJ_LO/ADJ_HI BCD correction passes for ADC/SBC.
module alu_op_sequencer #(
  parameter int W     = 8,
  parameter int OPC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OPC_W-1:0] op_code,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic             op_c,
  input  logic             op_v,
  input  logic             op_d,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_data,
  output logic             res_n,
  output logic             res_v,
  output logic             res_z,
  output logic             res_c,
  output logic             alu_sum_en,
  output logic             alu_and_en,
  output logic             alu_eor_en,
  output logic             alu_or_en,
  output logic             alu_sr_en,
  output logic             alu_inv_en,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic             alu_cin,
  input  logic [W-1:0]     alu_res,
  input  logic             alu_cout,
  input  logic             alu_ovf
);

  localparam logic [OPC_W-1:0] OP_ADC = 4'd0,  OP_SBC = 4'd1,  OP_AND = 4'd2,  OP_ORA = 4'd3;
  localparam logic [OPC_W-1:0] OP_EOR = 4'd4,  OP_LSR = 4'd5,  OP_ROR = 4'd6,  OP_ASL = 4'd7;
  localparam logic [OPC_W-1:0] OP_ROL = 4'd8,  OP_CMP = 4'd9,  OP_INC = 4'd10, OP_DEC = 4'd11;

`ifdef DECIMAL_MODE_EN
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ADJ_LO, S_ADJ_HI, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic             op_ready_q, op_ready_d, res_valid_q, res_valid_d;
  logic [W-1:0]     res_data_q, res_data_d;
  logic             res_n_q, res_n_d, res_v_q, res_v_d, res_z_q, res_z_d, res_c_q, res_c_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [W-1:0]     a_q, a_d;
  logic             c_q, c_d, v_q, v_d;
  logic             alu_sum_en_q, alu_sum_en_d, alu_and_en_q, alu_and_en_d;
  logic             alu_eor_en_q, alu_eor_en_d, alu_or_en_q, alu_or_en_d;
  logic             alu_sr_en_q, alu_sr_en_d, alu_inv_en_q, alu_inv_en_d;
  logic [W-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic             iss_sum, iss_and, iss_eor, iss_or, iss_sr, iss_inv, iss_cin;
  logic [W-1:0]     iss_a, iss_b, cap_res;
  logic             known_op, take_cout, take_ovf;
`ifdef DECIMAL_MODE_EN
  logic [W-1:0]     b_q, b_d, b_eff;
  logic             dec_q, dec_d, hc, is_adc;
`else
  logic             unused_op_d;
  assign unused_op_d = op_d;
`endif

  // ALU drive pattern for the incoming request, applied the cycle it is accepted
  always_comb begin
    iss_sum = 1'b0; iss_and = 1'b0; iss_eor = 1'b0; iss_or = 1'b0;
    iss_sr  = 1'b0; iss_inv = 1'b0; iss_cin = 1'b0;
    iss_a   = op_a; iss_b = '0;
    case (op_code)
      OP_ADC: begin iss_sum = 1'b1; iss_b = op_b; iss_cin = op_c; end
      OP_SBC: begin iss_sum = 1'b1; iss_inv = 1'b1; iss_b = op_b; iss_cin = op_c; end
      OP_AND: begin iss_and = 1'b1; iss_b = op_b; end
      OP_ORA: begin iss_or  = 1'b1; iss_b = op_b; end
      OP_EOR: begin iss_eor = 1'b1; iss_b = op_b; end
      OP_LSR: begin iss_sr  = 1'b1; end
      OP_ROR: begin iss_sr  = 1'b1; iss_cin = op_c; end
      OP_ASL: begin iss_sum = 1'b1; iss_b = op_a; end
      OP_ROL: begin iss_sum = 1'b1; iss_b = op_a; iss_cin = op_c; end
      OP_CMP: begin iss_sum = 1'b1; iss_inv = 1'b1; iss_b = op_b; iss_cin = 1'b1; end
      OP_INC: begin iss_sum = 1'b1; iss_cin = 1'b1; end
      OP_DEC: begin iss_sum = 1'b1; iss_b = '1; end
      default: iss_a = '0;
    endcase
  end

  // Next-state, latch and registered-output logic for the op sequencer
  always_comb begin
    state_d      = state_q;
    op_ready_d   = op_ready_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_n_d = res_n_q; res_v_d = res_v_q; res_z_d = res_z_q; res_c_d = res_c_q;
    opc_d = opc_q; a_d = a_q; c_d = c_q; v_d = v_q;
    alu_sum_en_d = 1'b0; alu_and_en_d = 1'b0; alu_eor_en_d = 1'b0;
    alu_or_en_d  = 1'b0; alu_sr_en_d  = 1'b0; alu_inv_en_d = 1'b0;
    alu_a_d = '0; alu_b_d = '0; alu_cin_d = 1'b0;
    known_op  = (opc_q <= OP_DEC);
    take_cout = opc_q inside {OP_ADC, OP_SBC, OP_CMP, OP_LSR, OP_ROR, OP_ASL, OP_ROL};
    take_ovf  = opc_q inside {OP_ADC, OP_SBC};
    cap_res   = known_op ? alu_res : a_q;
`ifdef DECIMAL_MODE_EN
    b_d    = b_q;
    dec_d  = dec_q;
    is_adc = (opc_q == OP_ADC);
    b_eff  = (opc_q == OP_SBC) ? ~b_q : b_q;
    hc     = a_q[4] ^ b_eff[4] ^ alu_res[4];
`endif
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          opc_d = op_code; a_d = op_a; c_d = op_c; v_d = op_v;
`ifdef DECIMAL_MODE_EN
          b_d   = op_b;
          dec_d = op_d && (op_code == OP_ADC || op_code == OP_SBC);
`endif
          alu_sum_en_d = iss_sum; alu_and_en_d = iss_and; alu_eor_en_d = iss_eor;
          alu_or_en_d  = iss_or;  alu_sr_en_d  = iss_sr;  alu_inv_en_d = iss_inv;
          alu_a_d = iss_a; alu_b_d = iss_b; alu_cin_d = iss_cin;
          op_ready_d = 1'b0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        res_data_d = cap_res;
        res_n_d    = cap_res[W-1];
        res_z_d    = (cap_res == '0);
        res_c_d    = take_cout ? alu_cout : c_q;
        res_v_d    = take_ovf ? alu_ovf : v_q;
        state_d    = S_DONE;
        res_valid_d = 1'b1;
`ifdef DECIMAL_MODE_EN
        if (dec_q) begin
          res_valid_d  = 1'b0;
          state_d      = S_ADJ_LO;
          alu_sum_en_d = 1'b1;
          alu_a_d      = alu_res;
          if (is_adc) alu_b_d = (hc || alu_res[3:0] > 4'd9) ? 8'h06 : 8'h00;
          else        alu_b_d = hc ? 8'h00 : 8'hFA;
        end
`endif
      end
`ifdef DECIMAL_MODE_EN
      S_ADJ_LO: begin
        state_d      = S_ADJ_HI;
        alu_sum_en_d = 1'b1;
        alu_a_d      = alu_res;
        if (is_adc) begin
          alu_b_d = (res_c_q || alu_res > 8'h99) ? 8'h60 : 8'h00;
          res_c_d = res_c_q || (alu_res > 8'h99);
        end else begin
          alu_b_d = res_c_q ? 8'h00 : 8'hA0;
        end
      end
      S_ADJ_HI: begin
        res_data_d  = alu_res;
        res_n_d     = alu_res[W-1];
        res_z_d     = (alu_res == '0);
        res_valid_d = 1'b1;
        state_d     = S_DONE;
      end
`endif
      S_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          op_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_ready_q <= 1'b1; res_valid_q <= 1'b0; res_data_q <= '0;
      res_n_q <= 1'b0; res_v_q <= 1'b0; res_z_q <= 1'b0; res_c_q <= 1'b0;
      opc_q <= '0; a_q <= '0; c_q <= 1'b0; v_q <= 1'b0;
      alu_sum_en_q <= 1'b0; alu_and_en_q <= 1'b0; alu_eor_en_q <= 1'b0;
      alu_or_en_q <= 1'b0; alu_sr_en_q <= 1'b0; alu_inv_en_q <= 1'b0;
      alu_a_q <= '0; alu_b_q <= '0; alu_cin_q <= 1'b0;
`ifdef DECIMAL_MODE_EN
      b_q <= '0; dec_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_ready_q <= op_ready_d; res_valid_q <= res_valid_d; res_data_q <= res_data_d;
      res_n_q <= res_n_d; res_v_q <= res_v_d; res_z_q <= res_z_d; res_c_q <= res_c_d;
      opc_q <= opc_d; a_q <= a_d; c_q <= c_d; v_q <= v_d;
      alu_sum_en_q <= alu_sum_en_d; alu_and_en_q <= alu_and_en_d; alu_eor_en_q <= alu_eor_en_d;
      alu_or_en_q <= alu_or_en_d; alu_sr_en_q <= alu_sr_en_d; alu_inv_en_q <= alu_inv_en_d;
      alu_a_q <= alu_a_d; alu_b_q <= alu_b_d; alu_cin_q <= alu_cin_d;
`ifdef DECIMAL_MODE_EN
      b_q <= b_d; dec_q <= dec_d;
`endif
    end
  end

  assign op_ready   = op_ready_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_n = res_n_q;
  assign res_v = res_v_q;
  assign res_z = res_z_q;
  assign res_c = res_c_q;
  assign alu_sum_en = alu_sum_en_q;
  assign alu_and_en = alu_and_en_q;
  assign alu_eor_en = alu_eor_en_q;
  assign alu_or_en  = alu_or_en_q;
  assign alu_sr_en  = alu_sr_en_q;
  assign alu_inv_en = alu_inv_en_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_cin    = alu_cin_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - random and directed checks of alu_op_sequencer against a 6502 arithmetic model
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst, op_valid, op_ready, op_c, op_v, op_d;
  logic [3:0] op_code;
  logic [7:0] op_a, op_b, res_data, alu_a, alu_b, alu_res, b_e;
  logic       res_valid, res_ready, res_n, res_v, res_z, res_c;
  logic       alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_sr_en, alu_inv_en, alu_cin;
  logic       alu_cout, alu_ovf;
  logic [8:0] sum9;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.W(8), .OPC_W(4)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_v(op_v), .op_d(op_d),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_n(res_n), .res_v(res_v), .res_z(res_z), .res_c(res_c),
    .alu_sum_en(alu_sum_en), .alu_and_en(alu_and_en), .alu_eor_en(alu_eor_en),
    .alu_or_en(alu_or_en), .alu_sr_en(alu_sr_en), .alu_inv_en(alu_inv_en),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_ovf(alu_ovf)
  );

  // Behavioural 6502 ALU answering the sequencer's drive lines
  always_comb begin
    b_e      = alu_inv_en ? ~alu_b : alu_b;
    sum9     = {1'b0, alu_a} + {1'b0, b_e} + {8'b0, alu_cin};
    alu_res  = 8'h00;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    if (alu_sum_en) begin
      alu_res  = sum9[7:0];
      alu_cout = sum9[8];
      alu_ovf  = (alu_a[7] == b_e[7]) && (sum9[7] != alu_a[7]);
    end else if (alu_and_en) alu_res = alu_a & b_e;
    else if (alu_or_en)  alu_res = alu_a | b_e;
    else if (alu_eor_en) alu_res = alu_a ^ b_e;
    else if (alu_sr_en) begin
      alu_res  = {alu_cin, alu_a[7:1]};
      alu_cout = alu_a[0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Result of a 6502 op as {res[7:0], N, V, Z, C}, from plain integer arithmetic
  function automatic logic [11:0] ref_op(input int code, input int a, input int b, input int c, input int v);
    int r, cf, vf, sa, sb, s;
    r = a; cf = c; vf = v;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (code)
      0: begin s = a + b + c; r = s % 256; cf = (s > 255) ? 1 : 0;
               s = sa + sb + c; vf = (s > 127 || s < -128) ? 1 : 0; end
      1: begin s = a - b - (1 - c); r = (s + 256) % 256; cf = (s >= 0) ? 1 : 0;
               s = sa - sb - (1 - c); vf = (s > 127 || s < -128) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a / 2; cf = a % 2; end
      6: begin r = a / 2 + 128 * c; cf = a % 2; end
      7: begin r = (a * 2) % 256; cf = a / 128; end
      8: begin r = (a * 2 + c) % 256; cf = a / 128; end
      9: begin r = (a - b + 256) % 256; cf = (a >= b) ? 1 : 0; end
      10: r = (a + 1) % 256;
      11: r = (a + 255) % 256;
      default: r = a;
    endcase
    return {r[7:0], r[7], vf[0], (r == 0), cf[0]};
  endfunction

  // ISSUE-cycle enable set {sum, and, eor, or, sr, inv} from the op table
  function automatic logic [5:0] exp_en(input int code);
    case (code)
      0, 7, 8, 10, 11: return 6'b100000;
      1, 9:            return 6'b100001;
      2:               return 6'b010000;
      3:               return 6'b000100;
      4:               return 6'b001000;
      5, 6:            return 6'b000010;
      default:         return 6'b000000;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] code, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic v, input logic d, input int hold);
    logic [11:0] exp;
    int lat, elat;
    exp  = ref_op(int'(code), int'(a), int'(b), int'(c), int'(v));
    elat = 1;
`ifdef DECIMAL_MODE_EN
    if (d && code <= 4'd1) begin
      int da, db, s, r;
      logic [7:0] rb;
      elat = 3;
      da = int'(a[7:4]) * 10 + int'(a[3:0]);
      db = int'(b[7:4]) * 10 + int'(b[3:0]);
      s  = (code == 4'd0) ? da + db + int'(c) : da - db - (1 - int'(c));
      if (code == 4'd0) exp[0] = (s > 99);
      r  = (s + 100) % 100;
      rb = 8'((r / 10) * 16 + r % 10);
      exp[11:4] = rb;
      exp[3]    = rb[7];
      exp[1]    = (rb == 8'h00);
    end
`endif
    @(negedge clk);
    check("ready_idle", 32'(op_ready), 32'd1);
    op_valid = 1'b1; op_code = code; op_a = a; op_b = b; op_c = c; op_v = v; op_d = d;
    @(posedge clk); #1;
    op_valid = 1'b0; op_a = 8'($urandom); op_b = 8'($urandom); op_c = 1'($urandom); op_v = 1'($urandom);
    check("issue_en", 32'({alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_sr_en, alu_inv_en}),
          32'(exp_en(int'(code))));
    lat = 0;
    while (!res_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    check("result", 32'({res_data, res_n, res_v, res_z, res_c}), 32'(exp));
    check("alu_quiet", 32'({alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_sr_en, alu_inv_en,
                            alu_cin, alu_a, alu_b}), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      op_valid = 1'($urandom); op_code = 4'($urandom);
      @(posedge clk); #1;
      check("hold_result", 32'({res_data, res_n, res_v, res_z, res_c}), 32'(exp));
      check("hold_handshake", 32'({op_ready, res_valid}), 32'b01);
    end
    @(negedge clk);
    op_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    check("release", 32'({op_ready, res_valid}), 32'b10);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    logic [3:0] code;
    logic [7:0] a, b;
    logic       d;
    rst = 1'b1; op_valid = 1'b0; op_code = 4'd0; op_a = 8'h00; op_b = 8'h00;
    op_c = 1'b0; op_v = 1'b0; op_d = 1'b0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_handshake", 32'({op_ready, res_valid}), 32'b10);
    check("reset_result", 32'({res_data, res_n, res_v, res_z, res_c}), 32'd0);
    check("reset_alu", 32'({alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_sr_en, alu_inv_en,
                            alu_cin, alu_a, alu_b}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(4'd0, 8'h09, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
    run_op(4'd1, 8'h50, 8'hB0, 1'b1, 1'b0, 1'b0, 0);
    run_op(4'd5, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    run_op(4'd6, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 5);
    run_op(4'd0, 8'h19, 8'h28, 1'b0, 1'b0, 1'b1, 0);
    run_op(4'd1, 8'h19, 8'h28, 1'b1, 1'b0, 1'b1, 1);
    run_op(4'd9, 8'h10, 8'h10, 1'b0, 1'b1, 1'b0, 0);
    run_op(4'd13, 8'h80, 8'h11, 1'b1, 1'b1, 1'b0, 2);

    // Reset in the middle of ISSUE
    @(negedge clk);
    op_valid = 1'b1; op_code = 4'd0; op_a = 8'h7F; op_b = 8'h01; op_c = 1'b1; op_d = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midissue_rst_handshake", 32'({op_ready, res_valid}), 32'b10);
    check("midissue_rst_result", 32'({res_data, res_n, res_v, res_z, res_c}), 32'd0);
    check("midissue_rst_alu", 32'({alu_sum_en, alu_and_en, alu_eor_en, alu_or_en, alu_sr_en,
                                   alu_inv_en, alu_cin, alu_a, alu_b}), 32'd0);
    @(posedge clk); #1;
    check("midissue_rst_state", 32'({op_ready, res_valid}), 32'b10);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 150; n++) begin
      code = 4'($urandom_range(0, 15));
      d    = 1'($urandom);
      a    = 8'($urandom);
      b    = 8'($urandom);
      if (d && code <= 4'd1) begin
        a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      run_op(code, a, b, 1'($urandom), 1'($urandom), d, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
